usb2_ep_router: RTL and testbench

Parametrised endpoint router between the USB 2.0 packet layer and a bank of `NUM_EP` endpoint buffers; successor to the fixed three-endpoint protocol mux. Latches the endpoint selected by each token and gates and muxes buffer handshakes only for the duration of the transaction. Owns per-endpoint transfer mode, data-toggle and halt (STALL) state, with a transaction watchdog. Sits between the packet layer and the `usb2_ep0`/`usb2_ep` instances.

---
 rtl/usb2_ep_router_if.sv | 33 +++
 rtl/usb2_ep_router.sv | 227 ++++++++++++++++++++++
 tb/tb_usb2_ep_router.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb2_ep_router_if.sv
// Packet-layer side of the endpoint router: token, end-of-transaction and
// buffer handshake signals.
//   master : packet layer (drives tokens and buffer strobes, sees returns)
//   slave  : usb2_ep_router (sees tokens and strobes, drives muxed returns)
interface usb2_ep_router_if;
   logic       token_valid;
   logic [3:0] token_endp;
   logic       token_dir;
   logic       xfer_done;
   logic       buf_in_wren;
   logic       buf_in_commit;
   logic       buf_out_arm;
   logic       buf_in_ready;
   logic       buf_in_commit_ack;
   logic       buf_out_hasdata;
   logic       buf_out_arm_ack;
   logic [7:0] buf_out_q;
   logic [9:0] buf_out_len;

   modport master (
      output token_valid, token_endp, token_dir, xfer_done,
      output buf_in_wren, buf_in_commit, buf_out_arm,
      input  buf_in_ready, buf_in_commit_ack, buf_out_hasdata, buf_out_arm_ack,
      input  buf_out_q, buf_out_len
   );

   modport slave (
      input  token_valid, token_endp, token_dir, xfer_done,
      input  buf_in_wren, buf_in_commit, buf_out_arm,
      output buf_in_ready, buf_in_commit_ack, buf_out_hasdata, buf_out_arm_ack,
      output buf_out_q, buf_out_len
   );
endinterface

// File: rtl/usb2_ep_router.sv
// Endpoint router between the USB 2.0 packet layer and NUM_EP endpoint
// buffers. Latches the endpoint addressed by a token, routes buffer strobes to
// it one-hot and muxes its returns back for the length of the transaction.
// Owns per-endpoint data toggle and halt (STALL) state plus a watchdog.
// Ports:
//   phy_clk, reset          clock, async active-high reset
//   pkt                     packet-side handshake (usb2_ep_router_if.slave)
//   setup_ack, data_toggle_act, halt_set, halt_clr, halt_endp, config_reset
//                           toggle/halt control
//   ep_buf_*                one-hot strobes out / flattened returns in
//   sel_valid, sel_endp, endp_mode, data_toggle, stall, sel_err, timeout
//                           selection status
//
// state  | meaning
// IDLE   | no transaction, all routing closed
// ACTIVE | token accepted, routing open to sel_endp unless stalled
module usb2_ep_router #(
   parameter int unsigned NUM_EP      = 4,
   parameter logic [31:0] EP_MODES    = 32'h0000_00A8,
   parameter logic [15:0] EP_IN_MASK  = 16'h0003,
   parameter logic [15:0] EP_OUT_MASK = 16'h0005,
   parameter int unsigned TIMEOUT_CYC = 8191
) (
   input  logic                   phy_clk,
   input  logic                   reset,
   usb2_ep_router_if.slave        pkt,
   input  logic                   setup_ack,
   input  logic                   data_toggle_act,
   input  logic                   halt_set,
   input  logic                   halt_clr,
   input  logic [3:0]             halt_endp,
   input  logic                   config_reset,
   output logic [NUM_EP-1:0]      ep_buf_in_wren,
   output logic [NUM_EP-1:0]      ep_buf_in_commit,
   output logic [NUM_EP-1:0]      ep_buf_out_arm,
   input  logic [NUM_EP-1:0]      ep_buf_in_ready,
   input  logic [NUM_EP-1:0]      ep_buf_in_commit_ack,
   input  logic [NUM_EP-1:0]      ep_buf_out_hasdata,
   input  logic [NUM_EP-1:0]      ep_buf_out_arm_ack,
   input  logic [8*NUM_EP-1:0]    ep_buf_out_q,
   input  logic [10*NUM_EP-1:0]   ep_buf_out_len,
   output logic                   sel_valid,
   output logic [3:0]             sel_endp,
   output logic [1:0]             endp_mode,
   output logic [1:0]             data_toggle,
   output logic                   stall,
   output logic                   sel_err,
   output logic                   timeout
);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
   localparam logic [1:0]  MODE_ISO = 2'd1;

   state_t              state_q, state_d;
   logic [3:0]          sel_endp_q, sel_endp_d;
   logic                stall_q, stall_d;
   logic                sel_err_q, sel_err_d;
   logic                timeout_q, timeout_d;
   logic [15:0]         wd_q, wd_d;
   logic [NUM_EP-1:0]   toggle_q, toggle_d;
   logic [NUM_EP-1:0]   halt_q, halt_d;

   logic [1:0]          ep_mode [NUM_EP];
   logic [NUM_EP-1:0]   sel_oh;
   logic                active, gate;
   logic                tok_ok, tok_halt;

   // ep0 is always control regardless of what EP_MODES says for it
   for (genvar g = 0; g < NUM_EP; g++) begin : g_mode
      if (g == 0) begin : g_ctl
         assign ep_mode[g] = 2'd0;
      end else begin : g_oth
         assign ep_mode[g] = EP_MODES[2*g +: 2];
      end
   end

   assign active = (state_q == ST_ACTIVE);
   assign gate   = active & ~stall_q;

   // Endpoints >= NUM_EP never match, which covers the range check
   always_comb begin
      tok_ok   = 1'b0;
      tok_halt = 1'b0;
      sel_oh   = '0;
      for (int i = 0; i < NUM_EP; i++) begin
         if (pkt.token_endp == 4'(i)) begin
            tok_ok   = pkt.token_dir ? EP_IN_MASK[i] : EP_OUT_MASK[i];
            tok_halt = halt_q[i];
         end
         sel_oh[i] = (sel_endp_q == 4'(i));
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_endp_d = sel_endp_q;
      stall_d    = stall_q;
      wd_d       = wd_q;
      sel_err_d  = 1'b0;
      timeout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wd_d = '0;
            if (pkt.token_valid) begin
               if (tok_ok) begin
                  state_d    = ST_ACTIVE;
                  sel_endp_d = pkt.token_endp;
                  stall_d    = tok_halt;
               end else begin
                  sel_err_d = 1'b1;
               end
            end
         end
         ST_ACTIVE: begin
            wd_d = wd_q + 16'd1;
            if (pkt.xfer_done) begin
               state_d    = ST_IDLE;
               sel_endp_d = '0;
               stall_d    = 1'b0;
            end else begin
               sel_err_d = pkt.token_valid;
               if (wd_q == WD_LAST) begin
                  timeout_d  = 1'b1;
                  state_d    = ST_IDLE;
                  sel_endp_d = '0;
                  stall_d    = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      toggle_d = toggle_q;
      halt_d   = halt_q;
      for (int i = 0; i < NUM_EP; i++) begin
         if (config_reset) begin
            toggle_d[i] = 1'b0;
            halt_d[i]   = 1'b0;
         end else if (halt_set && halt_endp == 4'(i)) begin
            halt_d[i] = 1'b1;
         end else if (halt_clr && halt_endp == 4'(i)) begin
            halt_d[i]   = 1'b0;
            toggle_d[i] = 1'b0;
         end else if (setup_ack && i == 0) begin
            toggle_d[i] = 1'b1;
            halt_d[i]   = 1'b0;
         end else if (data_toggle_act && active && sel_oh[i] && ep_mode[i] != MODE_ISO) begin
            toggle_d[i] = ~toggle_q[i];
         end
      end
   end

   always_ff @(posedge phy_clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sel_endp_q <= '0;
         stall_q    <= 1'b0;
         sel_err_q  <= 1'b0;
         timeout_q  <= 1'b0;
         wd_q       <= '0;
         toggle_q   <= '0;
         halt_q     <= '0;
      end else begin
         state_q    <= state_d;
         sel_endp_q <= sel_endp_d;
         stall_q    <= stall_d;
         sel_err_q  <= sel_err_d;
         timeout_q  <= timeout_d;
         wd_q       <= wd_d;
         toggle_q   <= toggle_d;
         halt_q     <= halt_d;
      end
   end

   assign ep_buf_in_wren   = {NUM_EP{gate & pkt.buf_in_wren}}   & sel_oh;
   assign ep_buf_in_commit = {NUM_EP{gate & pkt.buf_in_commit}} & sel_oh;
   assign ep_buf_out_arm   = {NUM_EP{gate & pkt.buf_out_arm}}   & sel_oh;

   logic       ret_in_ready, ret_commit_ack, ret_hasdata, ret_arm_ack;
   logic [7:0] ret_q;
   logic [9:0] ret_len;
   logic [1:0] ret_mode;
   logic       ret_tog;

   always_comb begin
      ret_in_ready   = 1'b0;
      ret_commit_ack = 1'b0;
      ret_hasdata    = 1'b0;
      ret_arm_ack    = 1'b0;
      ret_q          = '0;
      ret_len        = '0;
      ret_mode       = '0;
      ret_tog        = 1'b0;
      for (int i = 0; i < NUM_EP; i++) begin
         if (gate && sel_oh[i]) begin
            ret_in_ready   = ep_buf_in_ready[i];
            ret_commit_ack = ep_buf_in_commit_ack[i];
            ret_hasdata    = ep_buf_out_hasdata[i];
            ret_arm_ack    = ep_buf_out_arm_ack[i];
            ret_q          = ep_buf_out_q[8*i +: 8];
            ret_len        = ep_buf_out_len[10*i +: 10];
            ret_mode       = ep_mode[i];
            ret_tog        = toggle_q[i] & (ep_mode[i] != MODE_ISO);
         end
      end
   end

   assign pkt.buf_in_ready      = ret_in_ready;
   assign pkt.buf_in_commit_ack = ret_commit_ack;
   assign pkt.buf_out_hasdata   = ret_hasdata;
   assign pkt.buf_out_arm_ack   = ret_arm_ack;
   assign pkt.buf_out_q         = ret_q;
   assign pkt.buf_out_len       = ret_len;

   assign sel_valid   = active;
   assign sel_endp    = sel_endp_q;
   assign stall       = stall_q;
   assign endp_mode   = ret_mode;
   assign data_toggle = {1'b0, ret_tog};
   assign sel_err     = sel_err_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_usb2_ep_router.sv
module tb_usb2_ep_router;
   localparam int NUM_EP = 4;

   logic phy_clk = 1'b0;
   logic reset   = 1'b0;
   always #5 phy_clk = ~phy_clk;

   usb2_ep_router_if pkt();

   logic       setup_ack = 1'b0, data_toggle_act = 1'b0;
   logic       halt_set = 1'b0, halt_clr = 1'b0, config_reset = 1'b0;
   logic [3:0] halt_endp = 4'd0;

   logic [NUM_EP-1:0]    ep_buf_in_wren, ep_buf_in_commit, ep_buf_out_arm;
   logic [NUM_EP-1:0]    ep_buf_in_ready      = 4'b0110;
   logic [NUM_EP-1:0]    ep_buf_in_commit_ack = 4'b0100;
   logic [NUM_EP-1:0]    ep_buf_out_hasdata   = 4'b0010;
   logic [NUM_EP-1:0]    ep_buf_out_arm_ack   = 4'b0010;
   logic [8*NUM_EP-1:0]  ep_buf_out_q   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
   logic [10*NUM_EP-1:0] ep_buf_out_len = {10'd303, 10'd202, 10'd101, 10'd100};

   logic       sel_valid, stall, sel_err, timeout;
   logic [3:0] sel_endp;
   logic [1:0] endp_mode, data_toggle;

   int n_checks = 0;
   int n_err    = 0;

   // ep0 mode bits are 2'b11 to show ep0 is forced to control; ep3 is isochronous
   usb2_ep_router #(
      .NUM_EP(NUM_EP), .EP_MODES(32'h0000_006B), .EP_IN_MASK(16'h000B),
      .EP_OUT_MASK(16'h0005), .TIMEOUT_CYC(16)
   ) dut (
      .phy_clk(phy_clk), .reset(reset), .pkt(pkt),
      .setup_ack(setup_ack), .data_toggle_act(data_toggle_act),
      .halt_set(halt_set), .halt_clr(halt_clr), .halt_endp(halt_endp),
      .config_reset(config_reset),
      .ep_buf_in_wren(ep_buf_in_wren), .ep_buf_in_commit(ep_buf_in_commit),
      .ep_buf_out_arm(ep_buf_out_arm), .ep_buf_in_ready(ep_buf_in_ready),
      .ep_buf_in_commit_ack(ep_buf_in_commit_ack), .ep_buf_out_hasdata(ep_buf_out_hasdata),
      .ep_buf_out_arm_ack(ep_buf_out_arm_ack), .ep_buf_out_q(ep_buf_out_q),
      .ep_buf_out_len(ep_buf_out_len),
      .sel_valid(sel_valid), .sel_endp(sel_endp), .endp_mode(endp_mode),
      .data_toggle(data_toggle), .stall(stall), .sel_err(sel_err), .timeout(timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge phy_clk);
      #1;
   endtask

   task automatic send_token(input logic [3:0] e, input logic d);
      pkt.token_endp  = e;
      pkt.token_dir   = d;
      pkt.token_valid = 1'b1;
      tick();
      pkt.token_valid = 1'b0;
   endtask

   task automatic end_xfer();
      pkt.xfer_done = 1'b1;
      tick();
      pkt.xfer_done = 1'b0;
   endtask

   task automatic toggle_act();
      data_toggle_act = 1'b1;
      tick();
      data_toggle_act = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      pkt.token_valid = 1'b0; pkt.token_endp = 4'd0; pkt.token_dir = 1'b0;
      pkt.xfer_done = 1'b0; pkt.buf_in_wren = 1'b0; pkt.buf_in_commit = 1'b0;
      pkt.buf_out_arm = 1'b0;

      // reset
      #2 reset = 1'b1;
      #1;
      check("rst_sel_valid", sel_valid, 0);
      check("rst_wren", ep_buf_in_wren, 0);
      check("rst_out_q", pkt.buf_out_q, 0);
      check("rst_toggle", data_toggle, 0);
      check("rst_timeout", timeout, 0);
      repeat (2) @(posedge phy_clk);
      #1 reset = 1'b0;
      tick();

      // OUT to ep2, three writes, commit, done
      send_token(4'd2, 1'b0);
      check("ep2_sel_valid", sel_valid, 1);
      check("ep2_sel_endp", sel_endp, 2);
      check("ep2_stall", stall, 0);
      check("ep2_mode", endp_mode, 2);
      check("ep2_out_q", pkt.buf_out_q, 8'hC2);
      check("ep2_out_len", pkt.buf_out_len, 10'd202);
      check("ep2_in_ready", pkt.buf_in_ready, 1);
      check("ep2_hasdata", pkt.buf_out_hasdata, 0);
      for (int k = 0; k < 3; k++) begin
         pkt.buf_in_wren = 1'b1;
         #1;
         check("ep2_wren", ep_buf_in_wren, 4'b0100);
         tick();
         pkt.buf_in_wren = 1'b0;
         tick();
      end
      pkt.buf_in_commit = 1'b1;
      #1;
      check("ep2_commit", ep_buf_in_commit, 4'b0100);
      check("ep2_commit_ack", pkt.buf_in_commit_ack, 1);
      tick();
      pkt.buf_in_commit = 1'b0;
      end_xfer();
      check("done_sel_valid", sel_valid, 0);
      check("done_mode", endp_mode, 0);
      check("done_out_q", pkt.buf_out_q, 0);
      pkt.buf_in_wren = 1'b1;
      #1;
      check("idle_wren", ep_buf_in_wren, 0);
      pkt.buf_in_wren = 1'b0;
      tick();

      // ep1 toggle sequence: 0 -> 1 ; 1 -> 0 ; 0 -> 1
      send_token(4'd1, 1'b1);
      check("tog_t1", data_toggle, 0);
      toggle_act();
      check("tog_t1_after", data_toggle, 1);
      end_xfer();
      send_token(4'd1, 1'b1);
      check("tog_t2", data_toggle, 1);
      toggle_act();
      end_xfer();
      send_token(4'd1, 1'b1);
      check("tog_t3", data_toggle, 0);
      toggle_act();
      end_xfer();

      // halt ep1 (toggle is 1), stalled token, then clear
      halt_endp = 4'd1; halt_set = 1'b1;
      tick();
      halt_set = 1'b0;
      send_token(4'd1, 1'b1);
      check("halt_stall", stall, 1);
      check("halt_sel_valid", sel_valid, 1);
      check("halt_toggle", data_toggle, 0);
      check("halt_mode", endp_mode, 0);
      pkt.buf_out_arm = 1'b1;
      #1;
      check("halt_arm", ep_buf_out_arm, 0);
      check("halt_arm_ack", pkt.buf_out_arm_ack, 0);
      pkt.buf_out_arm = 1'b0;
      end_xfer();
      halt_clr = 1'b1;
      tick();
      halt_clr = 1'b0;
      send_token(4'd1, 1'b1);
      check("hclr_stall", stall, 0);
      check("hclr_toggle", data_toggle, 0);
      check("hclr_mode", endp_mode, 2);
      pkt.buf_out_arm = 1'b1;
      #1;
      check("hclr_arm", ep_buf_out_arm, 4'b0010);
      check("hclr_arm_ack", pkt.buf_out_arm_ack, 1);
      pkt.buf_out_arm = 1'b0;
      end_xfer();

      // ep0: halt set mid-transaction does not change stall; setup_ack clears halt
      send_token(4'd0, 1'b1);
      check("ep0_mode", endp_mode, 0);
      check("ep0_out_q", pkt.buf_out_q, 8'hA0);
      halt_endp = 4'd0; halt_set = 1'b1;
      tick();
      halt_set = 1'b0;
      check("ep0_mid_halt", stall, 0);
      end_xfer();
      send_token(4'd0, 1'b0);
      check("ep0_stalled", stall, 1);
      end_xfer();
      setup_ack = 1'b1;
      tick();
      setup_ack = 1'b0;
      send_token(4'd0, 1'b0);
      check("ep0_setup_stall", stall, 0);
      check("ep0_setup_tog", data_toggle, 1);
      end_xfer();

      // halt_clr and data_toggle_act on the same endpoint -> toggle 0
      send_token(4'd1, 1'b1);
      toggle_act();
      check("hc_act_pre", data_toggle, 1);
      halt_endp = 4'd1; halt_clr = 1'b1; data_toggle_act = 1'b1;
      tick();
      halt_clr = 1'b0; data_toggle_act = 1'b0;
      check("hc_act_tog", data_toggle, 0);
      end_xfer();

      // config_reset beats data_toggle_act
      send_token(4'd1, 1'b1);
      toggle_act();
      check("cr_pre", data_toggle, 1);
      config_reset = 1'b1; data_toggle_act = 1'b1;
      tick();
      config_reset = 1'b0; data_toggle_act = 1'b0;
      check("cr_tog", data_toggle, 0);
      end_xfer();

      // isochronous ep3 ignores toggle advance
      send_token(4'd3, 1'b1);
      check("iso_mode", endp_mode, 1);
      toggle_act();
      check("iso_tog", data_toggle, 0);
      end_xfer();

      // invalid tokens
      send_token(4'd2, 1'b1);
      check("inv_dir_err", sel_err, 1);
      check("inv_dir_idle", sel_valid, 0);
      tick();
      check("inv_err_pulse", sel_err, 0);
      send_token(4'd5, 1'b0);
      check("inv_range_err", sel_err, 1);
      check("inv_range_idle", sel_valid, 0);

      // token while ACTIVE keeps selection; token with done is dropped
      send_token(4'd2, 1'b0);
      check("act_err_none", sel_err, 0);
      send_token(4'd0, 1'b1);
      check("act_tok_err", sel_err, 1);
      check("act_tok_endp", sel_endp, 2);
      check("act_tok_valid", sel_valid, 1);
      pkt.xfer_done = 1'b1;
      send_token(4'd0, 1'b1);
      pkt.xfer_done = 1'b0;
      check("done_tok_err", sel_err, 0);
      check("done_tok_valid", sel_valid, 0);

      // watchdog expiry
      send_token(4'd2, 1'b0);
      n = 0;
      while (!timeout && n < 40) begin
         tick();
         n++;
      end
      check("wd_cycles", n, 16);
      check("wd_sel_valid", sel_valid, 0);
      tick();
      check("wd_pulse_end", timeout, 0);

      // done on the last watchdog cycle wins
      send_token(4'd2, 1'b0);
      repeat (15) tick();
      end_xfer();
      check("wd_done_to", timeout, 0);
      check("wd_done_valid", sel_valid, 0);

      // async reset mid-transaction
      send_token(4'd1, 1'b1);
      pkt.buf_out_arm = 1'b1;
      #1;
      check("ar_arm_pre", ep_buf_out_arm, 4'b0010);
      reset = 1'b1;
      #1;
      check("ar_arm", ep_buf_out_arm, 0);
      check("ar_sel_valid", sel_valid, 0);
      check("ar_out_q", pkt.buf_out_q, 0);
      check("ar_sel_endp", sel_endp, 0);
      pkt.buf_out_arm = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
